// File: rtl/multiwave_compute.sv
// Time-multiplexed multi-channel waveform generator: per-channel phase accumulators
// feeding a 4-stage sample/amplitude/saturation pipeline, one channel per cycle.
module multiwave_compute #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned AMP_W   = 16,
    parameter int unsigned OUT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(NCH)-1:0]     cfg_ch,
    input  logic signed [AMP_W-1:0]    cfg_amp,
    input  logic [PHASE_W-1:0]         cfg_phaseadd,
    input  logic [PHASE_W-1:0]         cfg_phaseoffset,
    input  logic [1:0]                 cfg_mode,
    input  logic                       cfg_enable,
    input  logic                       phase_sync,
    input  logic                       tick,
    output logic signed [OUT_W-1:0]    result,
    output logic [$clog2(NCH)-1:0]     result_ch,
    output logic                       result_valid,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int unsigned CH_W = $clog2(NCH);
    localparam int unsigned PW8  = AMP_W + 8;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);
    localparam logic signed [PW8-1:0] OUT_MAX = PW8'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [PW8-1:0] OUT_MIN = ~OUT_MAX;

    // round(127 * sin(2*pi*idx/4096)) in 2^28 fixed point, evaluated at elaboration only
    function automatic logic signed [7:0] sine_entry(input int unsigned idx);
        longint scale;
        longint x;
        longint term;
        longint acc;
        longint mag;
        int unsigned k;
        scale = 64'sd268435456;
        k = idx % 2048;
        if (k > 1024) begin
            k = 2048 - k;
        end
        x    = (longint'(k) * 64'sd843314857) / 64'sd2048;
        term = x;
        acc  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((term * x) / scale);
            term = (term * x) / scale;
            term = term / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        mag = (acc * 64'sd127 + scale / 2) / scale;
        if (idx >= 2048) begin
            mag = -mag;
        end
        return 8'(mag);
    endfunction

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] cnt_q, cnt_d;
    logic            issue;

    logic signed [AMP_W-1:0] amp_q   [NCH];
    logic [PHASE_W-1:0]      padd_q  [NCH];
    logic [PHASE_W-1:0]      poff_q  [NCH];
    logic [1:0]              mode_q  [NCH];
    logic                    en_q    [NCH];
    logic [PHASE_W-1:0]      phase_q [NCH];

    logic signed [7:0] sine_lut [4096];

    for (genvar gi = 0; gi < 4096; gi++) begin : g_lut
        localparam logic signed [7:0] SINE_VAL = sine_entry(gi);
        assign sine_lut[gi] = SINE_VAL;
    end

    // Sequencer: the tick cycle itself issues channel 0, RUN issues the rest
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        if (phase_sync) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        issue   = 1'b1;
                        state_d = StRun;
                        cnt_d   = cnt_q + CH_W'(1);
                    end
                end
                StRun: begin
                    issue = 1'b1;
                    if (cnt_q == LAST_CH) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CH_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                amp_q[i]  <= '0;
                padd_q[i] <= '0;
                poff_q[i] <= '0;
                mode_q[i] <= '0;
                en_q[i]   <= 1'b0;
            end
        end else if (cfg_we && (32'(cfg_ch) < NCH)) begin
            amp_q[cfg_ch]  <= cfg_amp;
            padd_q[cfg_ch] <= cfg_phaseadd;
            poff_q[cfg_ch] <= cfg_phaseoffset;
            mode_q[cfg_ch] <= cfg_mode;
            en_q[cfg_ch]   <= cfg_enable;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                phase_q[i] <= '0;
            end
        end else if (phase_sync) begin
            for (int i = 0; i < NCH; i++) begin
                phase_q[i] <= poff_q[i];
            end
        end else if (issue) begin
            phase_q[cnt_q] <= phase_q[cnt_q] + padd_q[cnt_q];
        end
    end

    // Pipeline data; validity is tracked separately so these need no reset
    logic [11:0]             s1_top;
    logic signed [AMP_W-1:0] s1_amp, s2_amp;
    logic [1:0]              s1_mode, s2_mode;
    logic                    s1_en, s2_en;
    logic [CH_W-1:0]         s1_ch, s2_ch, s3_ch;
    logic                    s1_last, s2_last, s3_last;
    logic                    s1_valid, s2_valid, s3_valid;
    logic signed [7:0]       sine_q, shape_q, shape, sample;
    logic signed [OUT_W-1:0] s3_res, sat;
    logic signed [PW8-1:0]   prod, shifted;
    logic [7:0]              t_byte, saw;
    logic [6:0]              tri7;

    always_comb begin
        t_byte = s1_top[11:4];
        saw    = {~t_byte[7], t_byte[6:0]};
        tri7   = t_byte[7] ? ~t_byte[6:0] : t_byte[6:0];
        shape  = '0;
        unique case (s1_mode)
            2'd1:    shape = t_byte[7] ? -8'sd127 : 8'sd127;
            2'd2:    shape = (saw == 8'h80) ? -8'sd127 : $signed(saw);
            2'd3:    shape = $signed({tri7, 1'b0} - 8'd127);
            default: shape = '0;
        endcase
    end

    always_comb begin
        sample  = (s2_mode == 2'd0) ? sine_q : shape_q;
        prod    = PW8'(s2_amp) * PW8'(sample);
        shifted = prod >>> 7;
        if (shifted > OUT_MAX) begin
            sat = OUT_MAX[OUT_W-1:0];
        end else if (shifted < OUT_MIN) begin
            sat = OUT_MIN[OUT_W-1:0];
        end else begin
            sat = shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        s1_top  <= phase_q[cnt_q][PHASE_W-1 -: 12];
        s1_amp  <= amp_q[cnt_q];
        s1_mode <= mode_q[cnt_q];
        s1_en   <= en_q[cnt_q];
        s1_ch   <= cnt_q;
        s1_last <= (cnt_q == LAST_CH);
        sine_q  <= sine_lut[s1_top];
        shape_q <= shape;
        s2_amp  <= s1_amp;
        s2_mode <= s1_mode;
        s2_en   <= s1_en;
        s2_ch   <= s1_ch;
        s2_last <= s1_last;
        s3_res  <= s2_en ? sat : '0;
        s3_ch   <= s2_ch;
        s3_last <= s2_last;
    end

    always_ff @(posedge clk) begin
        if (reset || phase_sync) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s3_valid     <= 1'b0;
            result_valid <= 1'b0;
            frame_done   <= 1'b0;
            result       <= '0;
            result_ch    <= '0;
            overrun      <= 1'b0;
        end else begin
            s1_valid     <= issue;
            s2_valid     <= s1_valid;
            s3_valid     <= s2_valid;
            result_valid <= s3_valid;
            frame_done   <= s3_valid & s3_last;
            result       <= s3_valid ? s3_res : '0;
            result_ch    <= s3_valid ? s3_ch : '0;
            overrun      <= tick && (state_q == StRun);
        end
    end

endmodule
